shot_collider: RTL

//  Owns the single player shot and is the source of every alien's hit input.

---
 rtl/shot_collider.sv | 136 +++++++++++++
 1 files changed

// File: rtl/shot_collider.sv
// Player shot owner: launch, climb per tick, then a serial one-alien-per-clk
// collision scan that reports the lowest-index live alien overlapped.
module shot_collider #(
    parameter int COLS       = 8,
    parameter int ROWS       = 4,
    parameter int WIDTH      = 10,
    parameter int SPACING    = 10,
    parameter int START_Y    = 460,
    parameter int SHOT_SPEED = 4,
    parameter int N          = COLS * ROWS,
    parameter int IW         = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          fire_req,
    input  logic [9:0]    player_x,
    input  logic [N-1:0]  alien_alive,
    input  logic [9:0]    grid_x_off,
    input  logic [9:0]    grid_y_off,
    output logic          shot_active,
    output logic [9:0]    shot_x,
    output logic [9:0]    shot_y,
    output logic          hit,
    output logic [IW-1:0] hit_idx,
    output logic          miss
);

    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int STEP = WIDTH + SPACING;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLY,
        S_SCAN,
        S_HIT,
        S_MISS
    } state_t;

    state_t        state, state_nx;
    logic [IW-1:0] idx;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [10:0]   ax, ay, sx, sy;
    logic          overlap;
    logic          strike;
    logic          last;

    // Row/col tracked alongside idx so bounds need no divider
    always_comb begin
        ax = {1'b0, grid_x_off} + 11'(col) * 11'(STEP);
        ay = {1'b0, grid_y_off} + 11'(row) * 11'(STEP);
        sx = {1'b0, shot_x};
        sy = {1'b0, shot_y};
        overlap = (sx >= ax) && (sx <= ax + 11'(WIDTH - 1)) &&
                  (sy >= ay) && (sy <= ay + 11'(WIDTH - 1));
        strike = alien_alive[idx] && overlap;
        last   = (idx == IW'(N - 1));
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (fire_req) state_nx = S_FLY;
            S_FLY: begin
                if (tick) begin
                    if (shot_y < 10'(SHOT_SPEED)) state_nx = S_MISS;
                    else                          state_nx = S_SCAN;
                end
            end
            S_SCAN: begin
                if (strike)    state_nx = S_HIT;
                else if (last) state_nx = S_FLY;
            end
            S_HIT:   state_nx = S_IDLE;
            S_MISS:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            col         <= '0;
            row         <= '0;
            shot_active <= 1'b0;
            shot_x      <= '0;
            shot_y      <= '0;
            hit_idx     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (fire_req) begin
                        shot_active <= 1'b1;
                        shot_x      <= player_x;
                        shot_y      <= 10'(START_Y);
                    end
                end
                S_FLY: begin
                    if (tick) begin
                        if (shot_y < 10'(SHOT_SPEED)) begin
                            shot_active <= 1'b0;
                        end else begin
                            shot_y <= shot_y - 10'(SHOT_SPEED);
                            idx    <= '0;
                            col    <= '0;
                            row    <= '0;
                        end
                    end
                end
                S_SCAN: begin
                    if (strike) begin
                        hit_idx     <= idx;
                        shot_active <= 1'b0;
                    end else if (!last) begin
                        idx <= idx + 1'b1;
                        if (col == CW'(COLS - 1)) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hit  = (state == S_HIT);
    assign miss = (state == S_MISS);

endmodule
